// File: rtl/down_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// down_capture_ctrl_if : downsampled word input and frame-buffer write port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface down_capture_ctrl_if #(
   parameter int ADDR_W = 17
);
   logic              validin;
   logic [7:0]        datain;
   logic              blankingin;
   logic              capture_req;
   logic              abort;
   logic              busy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              frame_done;
   logic              frame_err;

   modport master (
      output validin, datain, blankingin, capture_req, abort,
      input  busy, wr_en, wr_addr, wr_data, frame_done, frame_err
   );

   modport slave (
      input  validin, datain, blankingin, capture_req, abort,
      output busy, wr_en, wr_addr, wr_data, frame_done, frame_err
   );
endinterface

`default_nettype wire

// File: rtl/down_capture_ctrl.sv
// ----------------------------------------------------------------------------
// down_capture_ctrl : captures one whole downsampled frame into a frame buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module down_capture_ctrl #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int ADDR_W = 17
) (
   input  wire logic          clock,
   input  wire logic          reset,
   down_capture_ctrl_if.slave bus
);

   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      SYNC    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;

   logic              w_active;
   logic              w_blank;
   logic              w_last;
   logic              w_take;
   logic [ADDR_W-1:0] w_pix_addr;

   assign w_active   = bus.validin & ~bus.blankingin;
   assign w_blank    = bus.validin &  bus.blankingin;
   assign w_last     = (col_q == COL_W'(WIDTH - 1)) && (row_q == ROW_W'(HEIGHT - 1));
   assign w_pix_addr = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      pend_d    = pend_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      w_take    = 1'b0;

      if (bus.abort) begin
         state_d = IDLE;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.capture_req) begin
                  state_d = ARM;
                  err_d   = 1'b0;
               end
            end
            ARM: begin
               if (w_blank) begin
                  state_d = SYNC;
                  col_d   = '0;
                  row_d   = '0;
                  pend_d  = 1'b0;
               end
            end
            SYNC: begin
               if (w_active) begin
                  state_d = CAPTURE;
                  w_take  = 1'b1;
               end
            end
            CAPTURE: begin
               // pend_q: the final pixel is being written this cycle
               if (pend_q) begin
                  state_d = DONE;
               end else if (w_active) begin
                  w_take = 1'b1;
               end else if (w_blank) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
               pend_d  = 1'b0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (w_take) begin
         wr_en_d   = 1'b1;
         wr_addr_d = w_pix_addr;
         wr_data_d = bus.datain;
         if (w_last) begin
            pend_d = 1'b1;
         end else if (col_q == COL_W'(WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         pend_q    <= 1'b0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         pend_q    <= pend_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.frame_done = (state_q == DONE);
   assign bus.frame_err  = err_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_down_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_down_capture_ctrl : directed scoreboard bench, WIDTH=4 HEIGHT=2
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_down_capture_ctrl;

   localparam int WIDTH  = 4;
   localparam int HEIGHT = 2;
   localparam int ADDR_W = 3;

   typedef struct {
      bit               kind;   // 0 = write, 1 = frame_done
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      int                cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_assert;
   int   n_fail;
   exp_t exp_q[$];

   down_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   down_capture_ctrl #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: every write and frame_done pulse must match the queue head.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wr", {29'd0, bus.wr_addr}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_kind", 32'd0, {31'd0, e.kind});
            check("wr_cycle", cyc, e.cyc);
            check("wr_addr", {29'd0, bus.wr_addr}, {29'd0, e.addr});
            check("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
         end
      end
      if (bus.frame_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_kind", 32'd1, {31'd0, e.kind});
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.validin     = 1'b0;
      bus.blankingin  = 1'b0;
      bus.datain      = 8'h00;
      bus.capture_req = 1'b0;
      bus.abort       = 1'b0;
   endtask

   // Drive one cycle of input; optionally queue the write / frame_done it causes.
   task automatic send(input bit v, input bit b, input logic [7:0] d, input bit wr,
                       input logic [ADDR_W-1:0] a, input bit done, input bit ab);
      exp_t e;
      bus.validin    = v;
      bus.blankingin = b;
      bus.datain     = d;
      bus.abort      = ab;
      if (wr) begin
         e.kind = 1'b0; e.addr = a; e.data = d; e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      if (done) begin
         e.kind = 1'b1; e.addr = '0; e.data = '0; e.cyc = cyc + 2;
         exp_q.push_back(e);
      end
      step();
      clear_in();
   endtask

   task automatic req();
      bus.capture_req = 1'b1;
      step();
      clear_in();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // 3 active, 2 blank, 8 active 0x10..0x17; optional validin=0 gaps; expect writes when wr set.
   task automatic full_stream(input bit gaps, input bit wr);
      for (int i = 0; i < 3; i++) begin
         send(1, 0, 8'hA0 + 8'(i), 0, '0, 0, 0);
         if (gaps) send(0, 0, 8'h55, 0, '0, 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         send(1, 1, 8'hB0, 0, '0, 0, 0);
         if (gaps) send(0, 1, 8'h55, 0, '0, 0, 0);
      end
      for (int i = 0; i < 8; i++) begin
         send(1, 0, 8'h10 + 8'(i), wr, ADDR_W'(i), wr && (i == 7), 0);
         if (gaps) send(0, 0, 8'h66, 0, '0, 0, 0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  {31'd0, bus.busy},       32'd0);
      check({tag, "_wr_en"}, {31'd0, bus.wr_en},      32'd0);
      check({tag, "_waddr"}, {29'd0, bus.wr_addr},    32'd0);
      check({tag, "_wdata"}, {24'd0, bus.wr_data},    32'd0);
      check({tag, "_done"},  {31'd0, bus.frame_done}, 32'd0);
      check({tag, "_err"},   {31'd0, bus.frame_err},  32'd0);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      clear_in();
      rst = 1'b1;
      idle(3);
      check_all_zero("reset");
      rst = 1'b0;
      idle(2);

      // Full frame
      req();
      check("arm_busy", {31'd0, bus.busy}, 32'd1);
      full_stream(0, 1);
      idle(3);
      check("s1_busy", {31'd0, bus.busy}, 32'd0);
      check("s1_err", {31'd0, bus.frame_err}, 32'd0);
      check("s1_queue", exp_q.size(), 32'd0);

      // Same frame with idle gaps between words
      req();
      full_stream(1, 1);
      idle(3);
      check("s2_busy", {31'd0, bus.busy}, 32'd0);
      check("s2_queue", exp_q.size(), 32'd0);

      // Short frame
      req();
      send(1, 1, 8'hB0, 0, '0, 0, 0);
      for (int i = 0; i < 5; i++) send(1, 0, 8'h20 + 8'(i), 1, ADDR_W'(i), 0, 0);
      send(1, 1, 8'hB1, 0, '0, 0, 0);
      check("s3_err", {31'd0, bus.frame_err}, 32'd1);
      check("s3_busy", {31'd0, bus.busy}, 32'd0);
      idle(2);
      send(0, 0, 8'h00, 0, '0, 0, 1);
      check("s3_err_after_abort", {31'd0, bus.frame_err}, 32'd1);
      req();
      check("s3_err_cleared", {31'd0, bus.frame_err}, 32'd0);
      check("s3_rearm_busy", {31'd0, bus.busy}, 32'd1);
      send(0, 0, 8'h00, 0, '0, 0, 1);
      check("s3_queue", exp_q.size(), 32'd0);

      // Abort mid-capture, including the word arriving with abort
      req();
      send(1, 1, 8'hB0, 0, '0, 0, 0);
      for (int i = 0; i < 3; i++) send(1, 0, 8'h30 + 8'(i), 1, ADDR_W'(i), 0, 0);
      send(1, 0, 8'h33, 0, '0, 0, 1);
      check("s4_busy", {31'd0, bus.busy}, 32'd0);
      check("s4_err", {31'd0, bus.frame_err}, 32'd0);
      for (int i = 0; i < 5; i++) send(1, 0, 8'h40 + 8'(i), 0, '0, 0, 0);
      check("s4_queue", exp_q.size(), 32'd0);

      // Asynchronous reset mid-capture, then a stream without capture_req
      req();
      send(1, 1, 8'hB0, 0, '0, 0, 0);
      for (int i = 0; i < 2; i++) send(1, 0, 8'h50 + 8'(i), 1, ADDR_W'(i), 0, 0);
      idle(1);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      step();
      rst = 1'b0;
      full_stream(0, 0);
      idle(2);
      check_all_zero("s5_after");
      check("s5_queue", exp_q.size(), 32'd0);

      // capture_req with abort in IDLE, and capture_req during CAPTURE
      bus.capture_req = 1'b1;
      bus.abort       = 1'b1;
      step();
      clear_in();
      check("s6_req_abort_busy", {31'd0, bus.busy}, 32'd0);
      req();
      send(1, 1, 8'hB0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) bus.capture_req = 1'b1;
         send(1, 0, 8'h60 + 8'(i), 1, ADDR_W'(i), i == 7, 0);
      end
      idle(3);
      check("s6_busy", {31'd0, bus.busy}, 32'd0);
      check("s6_queue", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
